// File: rtl/dbus_ram_if.sv
// dbus_ram_if: data-bus request/response pair between the memory stage and its responder
interface dbus_ram_if;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  modport master (output dreq, input dresp);
  modport slave (input dreq, output dresp);
endinterface

// File: rtl/dbus_ram.sv
// dbus_ram: single-ported 64-bit data memory responding on the core data bus with fixed latency
module dbus_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  dbus_ram_if.slave   bus,
  output logic        err_o,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 3;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [63:0]   addr_q, wdata_q, data_q;
  logic [2:0]    size_q;
  logic [7:0]    strobe_q;
  logic          data_ok_q, err_q;
  logic [31:0]   rd_cnt_q, wr_cnt_q;
  logic [63:0]   mem [DEPTH_WORDS];
  logic [63:0]   off;
  logic [2:0]    amask;
  logic [AW-1:0] idx;
  logic          fault, wr;
  assign off   = addr_q - BASE_ADDR;
  assign idx   = off[AW+2:3];
  assign amask = 3'((4'd1 << size_q[1:0]) - 4'd1);
  assign wr    = |strobe_q;
  assign fault = addr_q < BASE_ADDR || off >= SPAN || size_q > 3'd3 || (addr_q[2:0] & amask) != 3'd0;
  assign bus.dresp = {rst && state_q == IDLE && bus.dreq.valid, data_ok_q, data_q};
  assign err_o    = err_q;
  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
  // Accept in IDLE, enter RESP on edge LATENCY after accept, then retire the access and update stats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      strobe_q  <= '0;
      wdata_q   <= '0;
      data_ok_q <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.dreq.valid) begin
          state_q  <= WAIT;
          cnt_q    <= 4'(LATENCY - 1);
          addr_q   <= bus.dreq.addr;
          size_q   <= bus.dreq.size;
          strobe_q <= bus.dreq.strobe;
          wdata_q  <= bus.dreq.data;
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            state_q   <= RESP;
            data_ok_q <= 1'b1;
            data_q    <= (wr || fault) ? '0 : mem[idx];
          end
        end
        RESP: begin
          state_q   <= IDLE;
          data_ok_q <= 1'b0;
          err_q     <= err_q | fault;
          rd_cnt_q  <= wr ? rd_cnt_q : rd_cnt_q + 32'd1;
          wr_cnt_q  <= wr ? wr_cnt_q + 32'd1 : wr_cnt_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Byte-merge a fault-free write into memory on the edge leaving RESP
  always_ff @(posedge clk) begin
    if (state_q == RESP && wr && !fault)
      for (int i = 0; i < 8; i++)
        if (strobe_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_dbus_ram.sv
// tb_dbus_ram: directed bench for dbus_ram at LATENCY 2 and 1 against a behavioural scoreboard
module tb_dbus_ram;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int DEPTH = 1024;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } req_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  req_t        vreq [2];
  logic        aok [2], dok [2], err [2];
  logic [63:0] rdat [2];
  logic [31:0] rdc [2], wrc [2];
  dbus_ram_if b0();
  dbus_ram_if b1();
  assign b0.dreq = vreq[0];
  assign b1.dreq = vreq[1];
  assign aok[0]  = b0.dresp.addr_ok;
  assign dok[0]  = b0.dresp.data_ok;
  assign rdat[0] = b0.dresp.data;
  assign aok[1]  = b1.dresp.addr_ok;
  assign dok[1]  = b1.dresp.data_ok;
  assign rdat[1] = b1.dresp.data;
  dbus_ram #(.LATENCY(2)) u0 (.clk(clk), .rst(rst), .bus(b0), .err_o(err[0]), .rd_cnt_o(rdc[0]), .wr_cnt_o(wrc[0]));
  dbus_ram #(.LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1), .err_o(err[1]), .rd_cnt_o(rdc[1]), .wr_cnt_o(wrc[1]));
  int checks = 0;
  int errors = 0;
  int          rem [2];
  req_t        cap [2];
  logic        m_err [2];
  logic [31:0] m_rd [2], m_wr [2];
  logic [63:0] mm [int];
  int          pulses [2];
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic bad(req_t r);
    int sz = 1 << r.size;
    return r.addr < BASE || r.addr >= BASE + 64'(8 * DEPTH) || r.size > 3'd3 || (int'(r.addr[2:0]) % sz) != 0;
  endfunction
  function automatic int widx(int ch, req_t r);
    return ch * DEPTH + int'(((r.addr - BASE) >> 3) % 64'(DEPTH));
  endfunction
  function automatic logic [63:0] merge(logic [63:0] o, logic [63:0] d, logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction
  always @(negedge clk) begin : cmp
    int k;
    logic ea;
    for (int ch = 0; ch < 2; ch++) begin
      if (!rst) begin
        chk($sformatf("rst_addr_ok%0d", ch), aok[ch], 0);
        chk($sformatf("rst_data_ok%0d", ch), dok[ch], 0);
        chk($sformatf("rst_data%0d", ch), rdat[ch], 0);
        chk($sformatf("rst_err%0d", ch), err[ch], 0);
        chk($sformatf("rst_rd_cnt%0d", ch), rdc[ch], 0);
        chk($sformatf("rst_wr_cnt%0d", ch), wrc[ch], 0);
        rem[ch] = 0;
        m_err[ch] = 1'b0;
        m_rd[ch] = '0;
        m_wr[ch] = '0;
      end else begin
        ea = rem[ch] == 0 && vreq[ch].valid;
        chk($sformatf("addr_ok%0d", ch), aok[ch], ea);
        chk($sformatf("data_ok%0d", ch), dok[ch], rem[ch] == 1);
        k = widx(ch, cap[ch]);
        if (rem[ch] == 1) begin
          pulses[ch]++;
          if (cap[ch].strobe != 0 || bad(cap[ch])) chk($sformatf("resp_zero%0d", ch), rdat[ch], 0);
          else if (mm.exists(k)) chk($sformatf("resp_data%0d", ch), rdat[ch], mm[k]);
        end
        chk($sformatf("err%0d", ch), err[ch], m_err[ch]);
        chk($sformatf("rd_cnt%0d", ch), rdc[ch], m_rd[ch]);
        chk($sformatf("wr_cnt%0d", ch), wrc[ch], m_wr[ch]);
        if (rem[ch] == 1) begin
          if (cap[ch].strobe != 0) begin
            m_wr[ch]++;
            if (!bad(cap[ch])) begin
              if (cap[ch].strobe == 8'hFF) mm[k] = cap[ch].data;
              else if (mm.exists(k)) mm[k] = merge(mm[k], cap[ch].data, cap[ch].strobe);
            end
          end else m_rd[ch]++;
          m_err[ch] = m_err[ch] | bad(cap[ch]);
        end
        if (rem[ch] > 0) rem[ch]--;
        else if (ea) begin
          cap[ch] = vreq[ch];
          rem[ch] = (ch == 0 ? 2 : 1) + 1;
        end
      end
    end
  end
  task automatic xfer(input int ch, input logic [63:0] a, input logic [2:0] sz, input logic [7:0] sb,
                      input logic [63:0] d, output logic [63:0] rd, output int lat);
    int n = 0;
    bit acc = 0;
    bit done = 0;
    vreq[ch] = '{valid: 1'b1, addr: a, size: sz, strobe: sb, data: d};
    rd = '0;
    lat = -1;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (acc) begin
        n++;
        if (dok[ch]) begin
          done = 1;
          rd = rdat[ch];
          lat = n - 1;
        end
      end else if (aok[ch]) acc = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer%0d_timeout: addr %h got no data_ok required one", ch, a);
    end
    @(posedge clk);
    #1 vreq[ch].valid = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [63:0] rd;
    int lat, p0;
    vreq[0] = '0;
    vreq[1] = '0;
    pulses[0] = 0;
    pulses[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data_ok", dok[0], 0);
    chk("reset_rd_cnt", rdc[0], 0);
    chk("reset_err", err[0], 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    xfer(0, 64'h8000_0008, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, rd, lat);
    chk("write_resp_zero", rd, 0);
    xfer(0, 64'h8000_0008, 3'd3, 8'h00, 64'h0, rd, lat);
    chk("read_data", rd, 64'h1122_3344_5566_7788);
    chk("read_latency", 64'(lat), 2);
    chk("rd_cnt_one", rdc[0], 1);
    xfer(0, BASE, 3'd3, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, rd, lat);
    xfer(0, 64'h8000_0003, 3'd0, 8'h08, 64'h0000_0000_AB00_0000, rd, lat);
    xfer(0, BASE, 3'd3, 8'h00, 64'h0, rd, lat);
    chk("byte_merge", rd, 64'hDEAD_BEEF_ABFE_F00D);
    chk("wr_cnt_three", wrc[0], 3);
    chk("err_clean", err[0], 0);
    xfer(0, 64'h8000_1FF8, 3'd3, 8'hFF, 64'h55AA_55AA_0F0F_F0F0, rd, lat);
    xfer(0, 64'h8000_1FF8, 3'd3, 8'h00, 64'h0, rd, lat);
    chk("last_word", rd, 64'h55AA_55AA_0F0F_F0F0);
    chk("err_still_clean", err[0], 0);
    xfer(0, 64'h7FFF_FFF8, 3'd3, 8'h00, 64'h0, rd, lat);
    chk("below_base_read", rd, 0);
    chk("fault_latency", 64'(lat), 2);
    chk("err_set", err[0], 1);
    xfer(0, 64'h8000_0002, 3'd2, 8'h3C, 64'h0000_1234_5678_0000, rd, lat);
    xfer(0, 64'h8000_2000, 3'd3, 8'h00, 64'h0, rd, lat);
    chk("past_end_read", rd, 0);
    xfer(0, BASE, 3'd5, 8'h00, 64'h0, rd, lat);
    chk("bad_size_read", rd, 0);
    xfer(0, BASE, 3'd3, 8'h00, 64'h0, rd, lat);
    chk("fault_no_write", rd, 64'hDEAD_BEEF_ABFE_F00D);
    chk("err_sticky", err[0], 1);
    xfer(0, 64'h8000_0010, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, rd, lat);
    vreq[0] = '{valid: 1'b1, addr: 64'h8000_0010, size: 3'd3, strobe: 8'hFF, data: 64'hFFFF_FFFF_FFFF_FFFF};
    for (int t = 0; t < 20 && !aok[0]; t++) @(negedge clk);
    @(posedge clk);
    #1;
    vreq[0].valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_err", err[0], 0);
    chk("mid_rst_wr_cnt", wrc[0], 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    xfer(0, 64'h8000_0010, 3'd3, 8'h00, 64'h0, rd, lat);
    chk("mid_rst_word", rd, 64'h0123_4567_89AB_CDEF);
    chk("mid_rst_wr_after", wrc[0], 0);
    chk("mid_rst_rd_after", rdc[0], 1);
    force u0.wr_cnt_q = 32'hFFFF_FFFF;
    m_wr[0] = 32'hFFFF_FFFF;
    #1 release u0.wr_cnt_q;
    xfer(0, 64'h8000_0018, 3'd3, 8'hFF, 64'h7777_0000_7777_0000, rd, lat);
    chk("wr_cnt_wrap", wrc[0], 0);
    p0 = pulses[1];
    xfer(1, BASE, 3'd3, 8'hFF, 64'hA1A2_A3A4_A5A6_A7A8, rd, lat);
    xfer(1, 64'h8000_0008, 3'd3, 8'hFF, 64'h0102_0304_0506_0708, rd, lat);
    xfer(1, 64'h8000_0008, 3'd3, 8'hF0, 64'h9988_7766_0000_0000, rd, lat);
    xfer(1, BASE, 3'd3, 8'h00, 64'h0, rd, lat);
    chk("l1_read0", rd, 64'hA1A2_A3A4_A5A6_A7A8);
    chk("l1_latency", 64'(lat), 1);
    xfer(1, 64'h8000_0008, 3'd3, 8'h00, 64'h0, rd, lat);
    chk("l1_read1", rd, 64'h9988_7766_0506_0708);
    repeat (2) @(posedge clk);
    #1;
    chk("l1_pulses", 64'(pulses[1] - p0), 5);
    chk("l1_wr_cnt", wrc[1], 3);
    chk("l1_rd_cnt", rdc[1], 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
